cas_key_loader: RTL and testbench

//  Sequential key-provisioning controller for a CAS-Lock-protected combinational core.

---
 rtl/cas_key_pkg.sv | 33 +++
 rtl/key_nvm_fetch.sv | 41 ++++
 rtl/cas_key_loader.sv | 138 +++++++++++++
 tb/tb_cas_key_loader.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cas_key_pkg.sv
// ============================================================================
// cas_key_pkg : shared types and helpers for the CAS-Lock key loader
// Revision    : 1.0
// ============================================================================
`default_nettype none

package cas_key_pkg;

  localparam int KEY_BYTES = 8;
  localparam int CHK_IDX   = KEY_BYTES;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_GAP   = 3'd2,
    S_CHECK = 3'd3,
    S_FAIL  = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  function automatic logic [7:0] xor_reduce_bytes(input logic [8*KEY_BYTES-1:0] shadow);
    logic [7:0] acc;
    acc = '0;
    for (int i = 0; i < KEY_BYTES; i++) begin
      acc = acc ^ shadow[8*i +: 8];
    end
    return acc;
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_nvm_fetch.sv
// ============================================================================
// key_nvm_fetch : single-byte NVM req/ack engine with per-request ack timeout
// Revision      : 1.0
// ============================================================================
`default_nettype none

module key_nvm_fetch #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       active,
  input  logic       nvm_ack,
  input  logic [7:0] nvm_data,
  output logic       nvm_req,
  output logic [7:0] rd_byte,
  output logic       done,
  output logic       timeout
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  logic [TMR_W-1:0] r_timer;

  // Timer idles at zero outside a request, so every request starts from zero.
  always_ff @(posedge clk) begin
    if (rst || !active || nvm_ack) begin
      r_timer <= '0;
    end else if (r_timer != TMR_W'(TIMEOUT)) begin
      r_timer <= r_timer + TMR_W'(1);
    end
  end

  assign nvm_req = active;
  assign rd_byte = nvm_data;
  assign done    = active & nvm_ack;
  assign timeout = active & ~nvm_ack & (r_timer == TMR_W'(TIMEOUT));

endmodule

`default_nettype wire

// File: rtl/cas_key_loader.sv
// ============================================================================
// cas_key_loader : fetches, verifies and commits the CAS-Lock key from NVM
// Revision       : 1.0
// ============================================================================
`default_nettype none

module cas_key_loader #(
  parameter int KEY_W     = 64,
  parameter int KEY_BYTES = 8,
  parameter int NVM_AW    = 8,
  parameter int KEY_BASE  = 0,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              nvm_req,
  output logic [NVM_AW-1:0] nvm_addr,
  input  logic              nvm_ack,
  input  logic [7:0]        nvm_data,
  output logic [KEY_W-1:0]  key_out,
  output logic              key_valid,
  output logic              busy,
  output logic              err,
  output logic [1:0]        retry_cnt
);

  import cas_key_pkg::*;

  localparam int IDX_W = $clog2(KEY_BYTES + 1);

  state_t           r_state;
  state_t           w_next;
  logic [IDX_W-1:0] r_idx;
  logic [KEY_W-1:0] r_shadow;
  logic [7:0]       r_chk;
  logic             w_active;
  logic             w_done;
  logic             w_timeout;
  logic [7:0]       w_byte;
  logic             w_match;
  logic             w_last_try;

  assign w_active   = (r_state == S_REQ);
  assign w_match    = (xor_reduce_bytes(r_shadow) == r_chk);
  assign w_last_try = (int'(retry_cnt) + 1) >= MAX_RETRY;
  assign nvm_addr   = NVM_AW'(KEY_BASE) + NVM_AW'(r_idx);
  assign busy       = (r_state == S_REQ) || (r_state == S_GAP) ||
                      (r_state == S_CHECK) || (r_state == S_FAIL);

  key_nvm_fetch #(
    .TIMEOUT (TIMEOUT)
  ) u_fetch (
    .clk      (clk),
    .rst      (rst),
    .active   (w_active),
    .nvm_ack  (nvm_ack),
    .nvm_data (nvm_data),
    .nvm_req  (nvm_req),
    .rd_byte  (w_byte),
    .done     (w_done),
    .timeout  (w_timeout)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: if (start) w_next = S_REQ;
      S_REQ: begin
        if (w_done)         w_next = S_GAP;
        else if (w_timeout) w_next = S_FAIL;
      end
      S_GAP:   w_next = (r_idx < IDX_W'(KEY_BYTES)) ? S_REQ : S_CHECK;
      S_CHECK: w_next = w_match ? S_DONE : S_FAIL;
      S_FAIL:  w_next = w_last_try ? S_ERR : S_REQ;
      default: w_next = S_IDLE;
    endcase
  end

  // key_out is only ever loaded from a verified shadow or cleared; never mid-load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_shadow  <= '0;
      r_chk     <= '0;
      key_out   <= '0;
      key_valid <= 1'b0;
      err       <= 1'b0;
      retry_cnt <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            r_idx     <= '0;
            r_shadow  <= '0;
            key_out   <= '0;
            key_valid <= 1'b0;
            err       <= 1'b0;
            retry_cnt <= '0;
          end
        end
        S_REQ: begin
          if (w_done) begin
            if (r_idx == IDX_W'(KEY_BYTES)) r_chk <= w_byte;
            for (int i = 0; i < KEY_BYTES; i++) begin
              if (r_idx == IDX_W'(i)) r_shadow[8*i +: 8] <= w_byte;
            end
          end
        end
        S_GAP: begin
          if (r_idx < IDX_W'(KEY_BYTES)) r_idx <= r_idx + IDX_W'(1);
        end
        S_CHECK: begin
          if (w_match) begin
            key_out   <= r_shadow;
            key_valid <= 1'b1;
          end
        end
        S_FAIL: begin
          retry_cnt <= retry_cnt + 2'd1;
          r_idx     <= '0;
          if (w_last_try) begin
            key_out   <= '0;
            key_valid <= 1'b0;
            err       <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cas_key_loader.sv
// ============================================================================
// tb_cas_key_loader : directed and randomized bench with an NVM responder model
// Revision          : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_cas_key_loader;

  localparam int c_base = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        nvm_req;
  logic [7:0]  nvm_addr;
  logic        nvm_ack;
  logic [7:0]  nvm_data;
  logic [63:0] key_out;
  logic        key_valid;
  logic        busy;
  logic        err;
  logic [1:0]  retry_cnt;

  always #5 clk = ~clk;

  cas_key_loader #(
    .KEY_W(64), .KEY_BYTES(8), .NVM_AW(8), .KEY_BASE(c_base), .MAX_RETRY(3), .TIMEOUT(15)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .nvm_req(nvm_req), .nvm_addr(nvm_addr),
    .nvm_ack(nvm_ack), .nvm_data(nvm_data), .key_out(key_out), .key_valid(key_valid),
    .busy(busy), .err(err), .retry_cnt(retry_cnt)
  );

  int          checks = 0;
  int          failures = 0;
  logic [7:0]  mem [256];
  int          ack_wait_max = 0;
  int          no_ack_addr = -1;
  bit          noise_en = 1'b0;
  int          req_count = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic: XOR of the eight key bytes.
  function automatic logic [7:0] model_sum(input logic [63:0] k);
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < 8; i++) s = s ^ 8'((k >> (8 * i)) & 64'hFF);
    return s;
  endfunction

  task automatic set_key(input logic [63:0] k, input logic [7:0] c);
    for (int i = 0; i < 8; i++) mem[c_base + i] = 8'((k >> (8 * i)) & 64'hFF);
    mem[c_base + 8] = c;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_result(input int budget, output int cyc);
    cyc = 0;
    while (!(key_valid === 1'b1 || err === 1'b1) && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    chk("settle_in_budget", 64'(key_valid === 1'b1 || err === 1'b1), 64'd1);
  endtask

  task automatic wait_req_addr(input int addr, input int budget);
    int n;
    n = 0;
    while (!(nvm_req === 1'b1 && int'(nvm_addr) == addr) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen_in_budget", 64'(n < budget), 64'd1);
  endtask

  // NVM responder: acks each request after a random wait; toggles ack noise while idle.
  initial begin
    int   wait_left;
    bit   in_req;
    logic prev_req;
    nvm_ack = 1'b0; nvm_data = 8'h00; in_req = 1'b0; prev_req = 1'b0; wait_left = 0;
    forever begin
      @(negedge clk);
      if (nvm_req === 1'b1 && prev_req !== 1'b1) req_count++;
      prev_req = nvm_req;
      if (nvm_req === 1'b1) begin
        if (!in_req) begin
          in_req = 1'b1;
          wait_left = int'($urandom_range(ack_wait_max, 0));
        end
        if (int'(nvm_addr) == no_ack_addr || wait_left > 0) begin
          nvm_ack = 1'b0;
          if (wait_left > 0) wait_left--;
        end else begin
          nvm_ack  = 1'b1;
          nvm_data = mem[nvm_addr];
        end
      end else begin
        in_req   = 1'b0;
        nvm_ack  = noise_en ? 1'($urandom_range(1, 0)) : 1'b0;
        nvm_data = 8'($urandom);
      end
    end
  end

  // A key that is not flagged valid must never be visible.
  always @(negedge clk) begin
    if (!rst && key_valid === 1'b0) chk("key_hidden_when_invalid", key_out, 64'd0);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc;
    int          base;
    int          n;
    logic [63:0] k;
    logic [7:0]  c;
    bit          ok;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_key_out", key_out, 64'd0);
    chk("rst_key_valid", 64'(key_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_retry", 64'(retry_cnt), 64'd0);
    chk("rst_nvm_req", 64'(nvm_req), 64'd0);
    rst = 1'b0;

    // 1: zero-wait load, commit latency
    set_key(64'h0807060504030201, 8'h08);
    pulse_start();
    chk("t1_busy_c0", 64'(busy), 64'd1);
    chk("t1_addr_c0", 64'(nvm_addr), 64'(c_base));
    wait_result(200, cyc);
    chk("t1_latency", 64'(cyc), 64'd19);
    chk("t1_key", key_out, 64'h0807060504030201);
    chk("t1_valid", 64'(key_valid), 64'd1);
    chk("t1_retry", 64'(retry_cnt), 64'd0);
    chk("t1_busy_done", 64'(busy), 64'd0);

    // 6: reload from DONE, with a start pulse during REQ that must be ignored
    k = {$urandom, $urandom};
    set_key(k, model_sum(k));
    base = req_count;
    pulse_start();
    chk("t6_valid_cleared", 64'(key_valid), 64'd0);
    chk("t6_key_cleared", key_out, 64'd0);
    repeat (2) @(negedge clk);
    pulse_start();
    wait_result(400, cyc);
    chk("t6_req_total", 64'(req_count - base), 64'd9);
    chk("t6_key", key_out, k);
    chk("t6_valid", 64'(key_valid), 64'd1);

    // 2: wrong checksum on the first pass only
    set_key(64'h0807060504030201, 8'h00);
    base = req_count;
    pulse_start();
    n = 0;
    while (req_count < base + 10 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t2_second_pass_started", 64'(req_count >= base + 10), 64'd1);
    chk("t2_not_valid_yet", 64'(key_valid), 64'd0);
    mem[c_base + 8] = 8'h08;
    wait_result(400, cyc);
    chk("t2_retry", 64'(retry_cnt), 64'd1);
    chk("t2_key", key_out, 64'h0807060504030201);
    chk("t2_valid", 64'(key_valid), 64'd1);
    chk("t2_req_total", 64'(req_count - base), 64'd18);

    // 3: checksum always wrong, ends in ERR
    set_key(64'h0807060504030201, 8'hFF);
    ack_wait_max = 1;
    base = req_count;
    pulse_start();
    wait_result(2000, cyc);
    repeat (2) @(negedge clk);
    chk("t3_req_total", 64'(req_count - base), 64'd27);
    chk("t3_err", 64'(err), 64'd1);
    chk("t3_key", key_out, 64'd0);
    chk("t3_nvm_req", 64'(nvm_req), 64'd0);
    chk("t3_retry", 64'(retry_cnt), 64'd3);
    chk("t3_valid", 64'(key_valid), 64'd0);
    chk("t3_busy", 64'(busy), 64'd0);

    // 4: byte 2 never acked -> 16 REQ cycles, FAIL, restart at base
    ack_wait_max = 0;
    no_ack_addr = c_base + 2;
    set_key(64'h0807060504030201, 8'h08);
    pulse_start();
    chk("t4_err_cleared", 64'(err), 64'd0);
    wait_req_addr(c_base + 2, 100);
    n = 1;
    while (nvm_req === 1'b1 && n < 40) begin
      @(negedge clk);
      if (nvm_req === 1'b1) n++;
    end
    chk("t4_req_cycles", 64'(n), 64'd16);
    chk("t4_busy_fail", 64'(busy), 64'd1);
    @(negedge clk);
    chk("t4_rereq", 64'(nvm_req), 64'd1);
    chk("t4_readdr", 64'(nvm_addr), 64'(c_base));
    no_ack_addr = -1;
    wait_result(400, cyc);
    chk("t4_retry", 64'(retry_cnt), 64'd1);
    chk("t4_valid", 64'(key_valid), 64'd1);
    chk("t4_key", key_out, 64'h0807060504030201);

    // 5: reset in the middle of byte 4
    k = {$urandom, $urandom};
    set_key(k, model_sum(k));
    pulse_start();
    wait_req_addr(c_base + 4, 100);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_key", key_out, 64'd0);
    chk("t5_valid", 64'(key_valid), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_err", 64'(err), 64'd0);
    chk("t5_retry", 64'(retry_cnt), 64'd0);
    chk("t5_nvm_req", 64'(nvm_req), 64'd0);
    pulse_start();
    chk("t5_restart_addr", 64'(nvm_addr), 64'(c_base));
    wait_result(400, cyc);
    chk("t5_key_after", key_out, k);

    // Randomized loads with ack latency, idle-ack noise and random checksums
    ack_wait_max = 3;
    noise_en = 1'b1;
    for (int it = 0; it < 6; it++) begin
      k = {$urandom, $urandom};
      c = ($urandom_range(1, 0) == 1) ? model_sum(k) : 8'($urandom);
      set_key(k, c);
      ok = (model_sum(k) == c);
      pulse_start();
      wait_result(3000, cyc);
      repeat (2) @(negedge clk);
      if (ok) begin
        chk("rnd_key", key_out, k);
        chk("rnd_valid", 64'(key_valid), 64'd1);
        chk("rnd_retry", 64'(retry_cnt), 64'd0);
      end else begin
        chk("rnd_err", 64'(err), 64'd1);
        chk("rnd_err_key", key_out, 64'd0);
        chk("rnd_err_retry", 64'(retry_cnt), 64'd3);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
